// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the single-clock and dual-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Occupancy and pointers need one bit beyond the address to tell full from empty
  function automatic int level_width(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE register array: synchronous write, asynchronous read.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int ASIZE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] word_we;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
    assign word_we[gi] = we && (waddr == ASIZE'(gi));
  end

  // Contents are wiped on reset so a fall-through output never shows stale words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) mem_reg[i] <= wdata;
      end
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with standard/FWFT read mode, level thresholds,
// sticky overflow/underflow flags and a synchronous flush.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int ASIZE     = 3,
  parameter int FWFT      = FIFO_STD,
  parameter int AFULL_TH  = (1 << ASIZE) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int LW = level_width(ASIZE);
  localparam logic [LW-1:0] DEPTH_L  = LW'(1 << ASIZE);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

  logic [LW-1:0]    wptr_reg, rptr_reg;
  logic             overflow_reg, underflow_reg;
  logic             w_acc, r_acc;
  logic [DSIZE-1:0] mem_rdata;

  // Flags come only from the registered pointers, never from winc/rinc
  assign level         = wptr_reg - rptr_reg;
  assign wfull         = (level == DEPTH_L);
  assign rempty        = (level == '0);
  assign walmost_full  = (level >= AFULL_L);
  assign ralmost_empty = (level <= AEMPTY_L);
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

  assign w_acc = winc && !wfull;
  assign r_acc = rinc && !rempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (clr) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (w_acc)           wptr_reg      <= wptr_reg + 1'b1;
      if (r_acc)           rptr_reg      <= rptr_reg + 1'b1;
      if (winc && wfull)   overflow_reg  <= 1'b1;
      if (rinc && rempty)  underflow_reg <= 1'b1;
    end
  end

  sync_fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (w_acc && !clr),
    .waddr(wptr_reg[ASIZE-1:0]),
    .wdata(wdata),
    .raddr(rptr_reg[ASIZE-1:0]),
    .rdata(mem_rdata)
  );

  if (FWFT == FIFO_FWFT) begin : g_fwft
    assign rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        rdata_reg <= '0;
      else if (clr)   rdata_reg <= '0;
      else if (r_acc) rdata_reg <= mem_rdata;
    end

    assign rdata = rdata_reg;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and scoreboard checks of sync_fifo in standard and FWFT modes.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       s_clr = 1'b0, s_winc = 1'b0, s_rinc = 1'b0;
  logic [7:0] s_wdata = 8'h00;
  logic       s_wfull, s_wafull, s_rempty, s_raempty, s_ovf, s_udf;
  logic [7:0] s_rdata;
  logic [3:0] s_level;

  // FWFT instance
  logic       f_clr = 1'b0, f_winc = 1'b0, f_rinc = 1'b0;
  logic [7:0] f_wdata = 8'h00;
  logic       f_wfull, f_wafull, f_rempty, f_raempty, f_ovf, f_udf;
  logic [7:0] f_rdata;
  logic [3:0] f_level;

  sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(FIFO_STD)) dut_std (
    .clk(clk), .rst(rst), .clr(s_clr), .wdata(s_wdata), .winc(s_winc),
    .wfull(s_wfull), .walmost_full(s_wafull), .rinc(s_rinc), .rdata(s_rdata),
    .rempty(s_rempty), .ralmost_empty(s_raempty), .level(s_level),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo #(.DSIZE(8), .ASIZE(3), .FWFT(FIFO_FWFT)) dut_fw (
    .clk(clk), .rst(rst), .clr(f_clr), .wdata(f_wdata), .winc(f_winc),
    .wfull(f_wfull), .walmost_full(f_wafull), .rinc(f_rinc), .rdata(f_rdata),
    .rempty(f_rempty), .ralmost_empty(f_raempty), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_s(input logic [7:0] d);
    s_winc = 1'b1;
    s_wdata = d;
    tick();
    s_winc = 1'b0;
    $display("std push 0x%02h -> level=%0d full=%0b ovf=%0b", d, s_level, s_wfull, s_ovf);
  endtask

  task automatic pop_s();
    s_rinc = 1'b1;
    tick();
    s_rinc = 1'b0;
    $display("std pop -> rdata=0x%02h level=%0d udf=%0b", s_rdata, s_level, s_udf);
  endtask

  initial begin
    int wacc, racc, n_wr;
    logic [7:0] d, e;

    // reset values
    #2;
    check("rst_wfull", s_wfull, 0);
    check("rst_rempty", s_rempty, 1);
    check("rst_level", s_level, 0);
    check("rst_ovf", s_ovf, 0);
    check("rst_udf", s_udf, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_wafull", s_wafull, 0);
    check("rst_raempty", s_raempty, 1);
    check("rst_f_rdata", f_rdata, 0);
    check("rst_f_rempty", f_rempty, 1);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // fill and drain
    for (int i = 0; i < 6; i++) begin
      push_s(8'h11 + 8'(i));
      check("fd_level", s_level, i + 1);
      check("fd_rempty", s_rempty, 0);
    end
    check("fd_wafull6", s_wafull, 1);
    check("fd_raempty6", s_raempty, 0);
    for (int i = 0; i < 6; i++) begin
      pop_s();
      check("fd_rdata", s_rdata, 32'h11 + i);
    end
    check("fd_level0", s_level, 0);
    check("fd_rempty0", s_rempty, 1);
    check("fd_raempty0", s_raempty, 1);

    // overflow
    for (int i = 0; i < 8; i++) begin
      push_s(8'h20 + 8'(i));
      check("ov_wafull", s_wafull, (i + 1 >= 6) ? 1 : 0);
      check("ov_wfull", s_wfull, (i == 7) ? 1 : 0);
    end
    check("ov_level8", s_level, 8);
    check("ov_ovf_pre", s_ovf, 0);
    for (int k = 0; k < 3; k++) begin
      push_s(8'h30 + 8'(k));
      check("ov_ovf", s_ovf, 1);
      check("ov_level", s_level, 8);
    end
    for (int i = 0; i < 8; i++) begin
      pop_s();
      check("ov_rdata", s_rdata, 32'h20 + i);
    end
    check("ov_rempty", s_rempty, 1);
    check("ov_sticky", s_ovf, 1);

    // underflow
    for (int k = 0; k < 3; k++) begin
      pop_s();
      check("un_udf", s_udf, 1);
      check("un_rdata", s_rdata, 32'h27);
      check("un_level", s_level, 0);
    end
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    $display("std clr -> udf=%0b ovf=%0b rdata=0x%02h", s_udf, s_ovf, s_rdata);
    check("clr_udf", s_udf, 0);
    check("clr_ovf", s_ovf, 0);
    check("clr_rdata", s_rdata, 0);

    // simultaneous at full and at empty
    for (int i = 0; i < 8; i++) push_s(8'h40 + 8'(i));
    s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'h99;
    tick();
    s_winc = 1'b0; s_rinc = 1'b0;
    $display("std push+pop at full -> level=%0d rdata=0x%02h", s_level, s_rdata);
    check("sf_level", s_level, 7);
    check("sf_ovf", s_ovf, 1);
    check("sf_rdata", s_rdata, 32'h40);
    check("sf_wfull", s_wfull, 0);
    for (int i = 0; i < 7; i++) begin
      pop_s();
      check("sf_drain", s_rdata, 32'h41 + i);
    end
    s_winc = 1'b1; s_rinc = 1'b1; s_wdata = 8'h77;
    tick();
    s_winc = 1'b0; s_rinc = 1'b0;
    $display("std push+pop at empty -> level=%0d rdata=0x%02h", s_level, s_rdata);
    check("se_level", s_level, 1);
    check("se_udf", s_udf, 1);
    check("se_rdata", s_rdata, 32'h47);
    pop_s();
    check("se_pop", s_rdata, 32'h77);

    // clr wins over a same-cycle write
    push_s(8'h55);
    s_clr = 1'b1; s_winc = 1'b1; s_wdata = 8'h66;
    tick();
    s_clr = 1'b0; s_winc = 1'b0;
    $display("std clr+push -> level=%0d", s_level);
    check("cp_level", s_level, 0);
    check("cp_rempty", s_rempty, 1);

    // FWFT
    f_winc = 1'b1; f_wdata = 8'hA5;
    tick();
    f_winc = 1'b0;
    $display("fwft push 0xa5 -> rempty=%0b rdata=0x%02h", f_rempty, f_rdata);
    check("fw_rempty", f_rempty, 0);
    check("fw_rdata", f_rdata, 32'hA5);
    f_winc = 1'b1; f_rinc = 1'b1; f_wdata = 8'h5A;
    tick();
    f_winc = 1'b0; f_rinc = 1'b0;
    $display("fwft pop+push 0x5a -> rempty=%0b rdata=0x%02h", f_rempty, f_rdata);
    check("fw_rdata2", f_rdata, 32'h5A);
    check("fw_rempty2", f_rempty, 0);
    check("fw_level", f_level, 1);
    f_rinc = 1'b1;
    tick();
    f_rinc = 1'b0;
    $display("fwft pop -> rempty=%0b level=%0d", f_rempty, f_level);
    check("fw_empty", f_rempty, 1);
    f_winc = 1'b1; f_wdata = 8'hC3;
    tick();
    f_winc = 1'b0;
    check("fw_rdata3", f_rdata, 32'hC3);

    // random traffic against a scoreboard
    n_wr = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      wacc = 0; racc = 0;
      s_winc = ($urandom_range(0, 99) < 55);
      s_rinc = ($urandom_range(0, 99) < 50);
      d = 8'($urandom_range(0, 255));
      s_wdata = d;
      if (s_winc && q.size() < 8) wacc = 1;
      if (s_rinc && q.size() > 0) racc = 1;
      tick();
      s_winc = 1'b0; s_rinc = 1'b0;
      if (racc != 0) begin
        e = q.pop_front();
        check("rnd_rdata", s_rdata, e);
      end
      if (wacc != 0) begin
        q.push_back(d);
        n_wr++;
      end
      check("rnd_level", s_level, q.size());
      $display("rnd %0d w=%0d r=%0d level=%0d rdata=0x%02h", cyc, wacc, racc, s_level, s_rdata);
    end
    check("rnd_wraps", (n_wr >= 48) ? 1 : 0, 1);

    // asynchronous reset between edges
    if (q.size() == 0) begin
      push_s(8'hE1);
      q.push_back(8'hE1);
    end
    check("pre_rst_rempty", s_rempty, 0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    $display("async rst -> level=%0d rempty=%0b rdata=0x%02h f_rdata=0x%02h", s_level, s_rempty, s_rdata, f_rdata);
    check("ar_level", s_level, 0);
    check("ar_rempty", s_rempty, 1);
    check("ar_wfull", s_wfull, 0);
    check("ar_rdata", s_rdata, 0);
    check("ar_ovf", s_ovf, 0);
    check("ar_udf", s_udf, 0);
    check("ar_wafull", s_wafull, 0);
    check("ar_raempty", s_raempty, 1);
    check("ar_f_rdata", f_rdata, 0);
    check("ar_f_rempty", f_rempty, 1);
    check("ar_f_level", f_level, 0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rempty", s_rempty, 1);
    check("post_f_rdata", f_rdata, 0);
    push_s(8'h3C);
    pop_s();
    check("post_rdata", s_rdata, 32'h3C);
    check("post_level", s_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the same-domain successor to the dual-clock `fifo`, used where producer and consumer share one clock and no Gray-code synchronisation is needed. It adds three things: selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty thresholds with an occupancy count, and sticky overflow/underflow flags with a synchronous flush.

## Interface
- `DSIZE`, 8: data width in bits.
- `ASIZE`, 3: address width; depth `DEPTH = 1 << ASIZE`.
- `FWFT`, 0:
  - 0 = standard mode: registered `rdata`, one-cycle read latency.
  - 1 = first-word-fall-through mode.
- `AFULL_TH`, `DEPTH-2`: `walmost_full` asserts when `level >= AFULL_TH`. Legal range 1..DEPTH.
- `AEMPTY_TH`, 2: `ralmost_empty` asserts when `level <= AEMPTY_TH`. Legal range 0..DEPTH-1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `clr`  in  1  synchronous flush.
- `wdata`  in  DSIZE  write data.
- `winc`  in  1  write request.
- `wfull`  out  1  FIFO full.
- `walmost_full`  out  1  level at or above `AFULL_TH`.
- `rinc`  in  1  read request (pop).
- `rdata`  out  DSIZE  read data.
- `rempty`  out  1  FIFO empty.
- `ralmost_empty`  out  1  level at or below `AEMPTY_TH`.
- `level`  out  ASIZE+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a write was attempted while full.
- `underflow`  out  1  sticky: a read was attempted while empty.

## Operation
- **Pointers:** `wptr` and `rptr` are ASIZE+1 bits wide, binary, and wrap modulo 2·DEPTH. The MSB disambiguates full from empty.
- **Level:** `level = wptr - rptr`, taken mod 2^(ASIZE+1).
- **Write accept:** `winc && !wfull`.
- **Read accept:** `rinc && !rempty`.
- **Full FIFO:** a write is rejected even when a read is accepted in the same cycle.
- **Empty FIFO:** a read is rejected even when a write is accepted in the same cycle.
- **Simultaneous accepted write and read:** `level` is unchanged; both pointers advance.
- **Flags:**
  - `wfull = (level == DEPTH)`.
  - `rempty = (level == 0)`.
  - `walmost_full` and `ralmost_empty` follow the threshold definitions above.
  - All flags are registered, or derived combinationally from registered pointers only; none depends on `winc`/`rinc`.
- **`overflow`:** set on `winc && wfull`.
- **`underflow`:** set on `rinc && rempty`.
- **Clearing the sticky flags:** both hold until `rst` or `clr`.
- **`clr`:**
  - Takes priority over `winc`/`rinc` in the same cycle.
  - Pointers go to 0; `overflow` and `underflow` go to 0.
  - In standard mode `rdata` goes to 0. Memory contents are not cleared.
- **Standard mode (`FWFT=0`):**
  - On an accepted read, `rdata` is loaded from `mem[rptr]` at that edge.
  - Otherwise `rdata` holds its value.
- **FWFT mode (`FWFT=1`):**
  - `rdata = mem[rptr[ASIZE-1:0]]`, continuously.
  - `rdata` is valid whenever `!rempty`; `rinc` acknowledges and pops the head.

## Timing
- **Reset values:**
  - `wfull` = 0, `rempty` = 1, `level` = 0, `overflow` = 0, `underflow` = 0, `rdata` = 0.
  - `walmost_full` = 0.
  - `ralmost_empty` = 1.
- **Write to flags:** a write accepted at edge N updates `level` and the flags after edge N. `rempty` falls in the cycle following edge N.
- **Standard read latency:** for a read accepted at edge N, the data is on `rdata` after edge N. A testbench sampling `rdata` at edge N+1 with `rvalid` registered from `rinc && !rempty` sees the correct word.
- **FWFT read latency:** the head word is visible in the same cycle `rempty` is low (zero added latency). After an accepted pop at edge N, the next head is visible after edge N.
- **Throughput:** one write and one read per cycle, sustained, at any level 1..DEPTH-1.
- **Reset mid-operation:** `rst` acts immediately and asynchronously. It restores every reset value and discards all contents.

## Structure
- Package `fifo_pkg` holds:
  - the mode constants `FIFO_STD` = 0 and `FIFO_FWFT` = 1;
  - the level-width helper (ASIZE+1).
- The async `fifo` reuses the same package.
- One sub-module, `sync_fifo_mem`: DEPTH×DSIZE register array with synchronous write and asynchronous read.
  - Written on an accepted write.
  - Read address is `rptr[ASIZE-1:0]`.
- Pointer, flag and sticky logic plus the standard-mode output register live in `sync_fifo`.

## Test plan
- **Fill and drain:** DSIZE=8, ASIZE=3, FWFT=0. Push 0x11..0x16, then pop 6 → `rdata` = 0x11..0x16 in order; `level` returns 0; `rempty` = 1.
- **Overflow:** push 8 words → `wfull` = 1, `level` = 8, `walmost_full` = 1 from level 6. Then push 3 more → writes ignored, `overflow` = 1 and stays set. Drain → exactly 8 words out, in order.
- **Underflow:** 3 pops on an empty FIFO → `underflow` = 1, `rdata` unchanged, `level` stays 0. Then `clr` → `underflow` = 0.
- **Simultaneous at full:** when full, drive `winc` and `rinc` together → read accepted, write rejected; `level` = 7, `overflow` = 1. When empty with both asserted → write accepted, read rejected; `level` = 1, `underflow` = 1.
- **FWFT:** FWFT=1. Push 0xA5 → `rempty` falls in the next cycle with `rdata` = 0xA5 already present. Pop with a concurrent push of 0x5A → `rdata` = 0x5A the next cycle; `rempty` stays 0.
- **Reset mid-operation:**
  - Random push/pop for 200 cycles against a scoreboard queue, with pointer wrap at least 3 times.
  - Then assert `rst` between clock edges → all outputs take reset values immediately.
  - Check that no stale data appears after release.
